uart_rx_frame_fsm: RTL and testbench
====================================

Name: uart_rx_frame_fsm

Overview:
Parametrised UART receive frame controller: the next generation of the fixed 8-data/parity/1-stop Rx state machine.
- Configurable data width, parity mode and stop-bit count.
- Deserialises sampled bits, checks parity and stop bits, and presents each frame through a valid/ready holding register with overrun detection.
- Sits between the Rx start detector/sampling-strobe generator and the host-side consumer.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY_EN, 1, 1 = parity bit present after data; 0 = no parity state
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, 1 or 2 stop bits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start_detected  input  1  falling edge seen on line; qualified by sampling_strobe
sampling_strobe  input  1  one-cycle pulse at bit centre; all state advances occur only on it
rx_bit  input  1  synchronised line value, valid when sampling_strobe=1
rx_ready  input  1  consumer accepts rx_data this cycle
rx_data  output  DATA_BITS  received frame data
rx_valid  output  1  rx_data/status held valid until accepted
parity_error  output  1  status of the frame in rx_data
framing_error  output  1  any stop bit sampled low, for the frame in rx_data
overrun  output  1  one-cycle pulse: unaccepted frame overwritten
data_is_available  output  1  registered: FSM in DATA
is_parity_stage  output  1  registered: FSM in PARITY
data_is_valid  output  1  registered: FSM in final stop state

Behaviour:
- Reset: state IDLE; bit counter 0; shift register 0; every output 0. Reset mid-frame aborts the frame with no rx_valid and no error flags.
- State encoding: IDLE, START, DATA, PARITY, STOP1, STOP2. No transition occurs without sampling_strobe.
- IDLE -> START: on strobe with start_detected=1.
- START:
  - rx_bit=1 on strobe: false start, go to IDLE, no frame produced.
  - Otherwise go to DATA with bit counter cleared.
- DATA:
  - Each strobe writes shift[bit_cnt] <= rx_bit and increments bit_cnt.
  - On the strobe where bit_cnt == DATA_BITS-1, go to PARITY if PARITY_EN, else STOP1.
- PARITY: strobe captures the parity bit, go to STOP1.
- STOP1: strobe; rx_bit=0 sets the framing flag. Go to STOP2 if STOP_BITS==2, else complete the frame and go to IDLE.
- STOP2: strobe; rx_bit=0 sets the framing flag. Complete the frame and go to IDLE.
- A start_detected coinciding with the final stop strobe is ignored; detection restarts in IDLE.
- Status flags are registered from the current state, so each asserts one clk after state entry and clears one clk after exit. data_is_valid is therefore aligned with the completed frame.
- Parity check:
  - expected = (^data) ^ PARITY_ODD.
  - parity_error = PARITY_EN & (received != expected).
- Frame completion, on the clk after the final stop strobe:
  - rx_data, parity_error and framing_error load.
  - rx_valid <= 1.
- Handshake:
  - rx_valid drops the cycle after rx_valid & rx_ready.
  - rx_data and error flags stay stable while rx_valid=1 and unaccepted.
- Completion while rx_valid=1 and rx_ready=0: new frame overwrites, rx_valid stays 1, overrun pulses for 1 cycle.
- Completion in the same cycle as acceptance: new frame loads, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 clk after the last stop-bit strobe.
- Width rules:
  - bit_cnt width is $clog2(DATA_BITS).
  - No overflow is possible, since the counter is compared before increment.
- Illegal parameter values: generate-time error in simulation (initial check); not synthesisable.

Decomposition:
- Package uart_rx_pkg: state-encoding localparams (3-bit), parity mode constants (PAR_EVEN, PAR_ODD), and a legal-range check function for DATA_BITS/STOP_BITS.
- One sub-module, uart_rx_holding_reg: DATA_BITS+2 wide data/status register with valid/ready, overwrite and overrun logic.
- The FSM, shift register and parity check stay in the top block.

Test Plan:
- Default 8E1, frame 0xA5 (data 1,0,1,0,0,1,0,1 LSB first, parity 0, stop 1), rx_ready=1:
  - rx_data=0xA5 with rx_valid for 1 cycle, parity_error=0, framing_error=0.
  - data_is_available high for 8 bit periods (one clk lagged).
- 8E1, frame 0x3C with parity bit 1 -> rx_data=0x3C, parity_error=1.
- DATA_BITS=7, PARITY_ODD=1, STOP_BITS=2, frame 0x55 with STOP2 sampled 0 -> rx_data=0x55, framing_error=1, parity_error=0.
- Two 8N1 frames 0x11 then 0x22, rx_ready=0 throughout -> overrun pulses once at the second completion; rx_data=0x22; rx_valid stays 1 until rx_ready asserted.
- rx_bit=1 at the START strobe -> FSM returns to IDLE; no rx_valid; data_is_available never asserts.
- reset asserted during DATA bit 4 of 0xFF -> all outputs 0 next cycle; the following clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// parity mode constants and the parameter legality check.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic bit params_legal(input int data_bits, input int stop_bits,
                                      input int parity_en, input int parity_odd);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (parity_en == 0 || parity_en == 1) &&
           (parity_odd == 0 || parity_odd == 1);
  endfunction

endpackage

// File: rtl/uart_rx_holding_reg.sv
// Host-side holding register: one frame (data + status) behind a valid/ready
// handshake; a new frame overwrites an unaccepted one and flags overrun.
module uart_rx_holding_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] word,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      word    <= '0;
      overrun <= 1'b0;
    end else begin
      // Simultaneous load and acceptance is a clean hand-over, not an overrun.
      overrun <= load & valid & ~ready;
      if (load) begin
        word  <= load_word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_fsm.sv
// UART receive frame controller: deserialises strobed bits, checks parity and
// stop bits, and hands completed frames to the holding register.
module uart_rx_frame_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_detected,
  input  logic                 sampling_strobe,
  input  logic                 rx_bit,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 data_is_available,
  output logic                 is_parity_stage,
  output logic                 data_is_valid
);

  if (!params_legal(DATA_BITS, STOP_BITS, PARITY_EN, PARITY_ODD)) begin : g_bad_params
    $error("uart_rx_frame_fsm: illegal parameter combination");
  end

  localparam int             CNT_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic           PAR_SENSE  = (PARITY_ODD == PAR_ODD);
  localparam state_t         FINAL_STOP = (STOP_BITS == 2) ? STOP2 : STOP1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   parity_bit_q;
  logic                   framing_q;
  logic                   frame_done;
  logic                   frame_perr;
  logic                   frame_ferr;
  logic [DATA_BITS+1:0]   hold_word;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    if (sampling_strobe) begin
      unique case (state_q)
        IDLE:   if (start_detected) state_d = START;
        START:  state_d = rx_bit ? IDLE : DATA;
        DATA:   if (bit_cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP1;
        PARITY: state_d = STOP1;
        STOP1: begin
          if (STOP_BITS == 2) begin
            state_d = STOP2;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
        STOP2: begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The final stop bit is still on rx_bit when the frame completes.
  assign frame_ferr = framing_q | ~rx_bit;
  assign frame_perr = (PARITY_EN != 0) & (parity_bit_q ^ (^shift_q) ^ PAR_SENSE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      bit_cnt_q         <= '0;
      shift_q           <= '0;
      parity_bit_q      <= 1'b0;
      framing_q         <= 1'b0;
      data_is_available <= 1'b0;
      is_parity_stage   <= 1'b0;
      data_is_valid     <= 1'b0;
    end else begin
      state_q           <= state_d;
      data_is_available <= (state_q == DATA);
      is_parity_stage   <= (state_q == PARITY);
      data_is_valid     <= (state_q == FINAL_STOP);
      if (sampling_strobe) begin
        case (state_q)
          START: begin
            bit_cnt_q <= '0;
            framing_q <= 1'b0;
          end
          DATA: begin
            shift_q[bit_cnt_q] <= rx_bit;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
          end
          PARITY: parity_bit_q <= rx_bit;
          STOP1:  if (!rx_bit) framing_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  uart_rx_holding_reg #(
    .WIDTH(DATA_BITS + 2)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (frame_done),
    .load_word({frame_perr, frame_ferr, shift_q}),
    .ready    (rx_ready),
    .valid    (rx_valid),
    .word     (hold_word),
    .overrun  (overrun)
  );

  assign {parity_error, framing_error, rx_data} = hold_word;

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Directed bench for uart_rx_frame_fsm in 8E1, 7O2 and 8N1 configurations.
module tb_uart_rx_frame_fsm;

  localparam int P = 4;  // clocks per bit period

  logic       clk;
  logic       reset;
  logic [2:0] sd, st, rb, rr;
  logic [2:0] vld, perr, ferr, ovr, dav, ips, div;
  logic [7:0] d_8e1, d_8n1;
  logic [6:0] d_7o2;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt[3] = '{default: 0};
  int dcnt[3] = '{default: 0};
  int pcnt[3] = '{default: 0};
  int ocnt[3] = '{default: 0};
  int v0, d0, p0, o0;

  uart_rx_frame_fsm #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .start_detected(sd[0]), .sampling_strobe(st[0]),
    .rx_bit(rb[0]), .rx_ready(rr[0]), .rx_data(d_8e1), .rx_valid(vld[0]),
    .parity_error(perr[0]), .framing_error(ferr[0]), .overrun(ovr[0]),
    .data_is_available(dav[0]), .is_parity_stage(ips[0]), .data_is_valid(div[0]));

  uart_rx_frame_fsm #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .start_detected(sd[1]), .sampling_strobe(st[1]),
    .rx_bit(rb[1]), .rx_ready(rr[1]), .rx_data(d_7o2), .rx_valid(vld[1]),
    .parity_error(perr[1]), .framing_error(ferr[1]), .overrun(ovr[1]),
    .data_is_available(dav[1]), .is_parity_stage(ips[1]), .data_is_valid(div[1]));

  uart_rx_frame_fsm #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .start_detected(sd[2]), .sampling_strobe(st[2]),
    .rx_bit(rb[2]), .rx_ready(rr[2]), .rx_data(d_8n1), .rx_valid(vld[2]),
    .parity_error(perr[2]), .framing_error(ferr[2]), .overrun(ovr[2]),
    .data_is_available(dav[2]), .is_parity_stage(ips[2]), .data_is_valid(div[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) vcnt[i] <= vcnt[i] + 1;
      if (dav[i]) dcnt[i] <= dcnt[i] + 1;
      if (ips[i]) pcnt[i] <= pcnt[i] + 1;
      if (ovr[i]) ocnt[i] <= ocnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the strobed edge.
  task automatic strobe(input int u, input logic sdv, input logic b);
    st[u] = 1'b1;
    sd[u] = sdv;
    rb[u] = b;
    @(posedge clk);
    @(negedge clk);
    st[u] = 1'b0;
    sd[u] = 1'b0;
  endtask

  task automatic send_frame(input int u, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par, input int nstop,
                            input logic s1, input logic s2, input bit acc_last);
    logic last;
    strobe(u, 1'b1, 1'b0); gap(P - 1);
    strobe(u, 1'b0, 1'b0); gap(P - 1);
    for (int i = 0; i < nbits; i++) begin
      strobe(u, 1'b0, data[i]); gap(P - 1);
    end
    if (has_par) begin
      strobe(u, 1'b0, par); gap(P - 1);
    end
    if (nstop == 2) begin
      strobe(u, 1'b0, s1); gap(P - 1);
      last = s2;
    end else begin
      last = s1;
    end
    if (acc_last) rr[u] = 1'b1;
    strobe(u, 1'b0, last);
    if (acc_last) rr[u] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sd = '0; st = '0; rb = '0; rr = 3'b011;
    gap(3);
    check("reset_8e1", {d_8e1, vld[0], perr[0], ferr[0], ovr[0], dav[0], ips[0], div[0]}, 0);
    check("reset_7o2", {d_7o2, vld[1], perr[1], ferr[1], ovr[1], dav[1], ips[1], div[1]}, 0);
    reset = 1'b0;
    gap(2);

    // 8E1 0xA5, even parity bit 0
    v0 = vcnt[0]; d0 = dcnt[0]; p0 = pcnt[0];
    send_frame(0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, 1'b1, 0);
    check("a5_data", d_8e1, 8'hA5);
    check("a5_valid", vld[0], 1'b1);
    check("a5_perr", perr[0], 1'b0);
    check("a5_ferr", ferr[0], 1'b0);
    check("a5_dvalid", div[0], 1'b1);
    gap(2);
    check("a5_valid_drop", vld[0], 1'b0);
    check("a5_valid_cycles", vcnt[0] - v0, 1);
    check("a5_dav_cycles", dcnt[0] - d0, 8 * P);
    check("a5_par_cycles", pcnt[0] - p0, P);

    // 8E1 0x3C with wrong parity bit 1
    send_frame(0, 9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1, 0);
    check("3c_data", d_8e1, 8'h3C);
    check("3c_perr", perr[0], 1'b1);
    check("3c_ferr", ferr[0], 1'b0);
    gap(2);

    // 7O2 0x55: four ones so odd parity bit is 1; second stop sampled low
    send_frame(1, 9'h055, 7, 1, 1'b1, 2, 1'b1, 1'b0, 0);
    check("55_data", d_7o2, 7'h55);
    check("55_valid", vld[1], 1'b1);
    check("55_ferr", ferr[1], 1'b1);
    check("55_perr", perr[1], 1'b0);
    check("55_dvalid", div[1], 1'b1);
    gap(2);

    // 8N1 overrun with rx_ready held low
    o0 = ocnt[2];
    send_frame(2, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0);
    check("11_data", d_8n1, 8'h11);
    check("11_ovr", ovr[2], 1'b0);
    gap(P);
    send_frame(2, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0);
    check("22_ovr", ovr[2], 1'b1);
    check("22_data", d_8n1, 8'h22);
    check("22_valid", vld[2], 1'b1);
    check("22_perr", perr[2], 1'b0);
    gap(1);
    check("22_ovr_pulse", ovr[2], 1'b0);
    gap(6);
    check("22_valid_held", vld[2], 1'b1);
    check("22_ovr_count", ocnt[2] - o0, 1);
    rr[2] = 1'b1;
    gap(1);
    rr[2] = 1'b0;
    check("22_accepted", vld[2], 1'b0);

    // 8N1 completion coinciding with acceptance: no overrun
    o0 = ocnt[2];
    send_frame(2, 9'h033, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0);
    gap(2);
    send_frame(2, 9'h044, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1);
    check("44_valid", vld[2], 1'b1);
    check("44_data", d_8n1, 8'h44);
    check("44_ovr", ovr[2], 1'b0);
    gap(2);
    check("44_ovr_count", ocnt[2] - o0, 0);
    gap(2);

    // 8E1 false start, then recovery frame 0x5A
    v0 = vcnt[0]; d0 = dcnt[0];
    strobe(0, 1'b1, 1'b0); gap(P - 1);
    strobe(0, 1'b0, 1'b1); gap(10 * P);
    check("fs_valid", vcnt[0] - v0, 0);
    check("fs_dav", dcnt[0] - d0, 0);
    send_frame(0, 9'h05A, 8, 1, 1'b0, 1, 1'b1, 1'b1, 0);
    check("5a_data", d_8e1, 8'h5A);
    check("5a_valid", vld[0], 1'b1);
    gap(2);

    // Reset during data bit 4 of 0xFF, then clean 0x81
    strobe(0, 1'b1, 1'b0); gap(P - 1);
    strobe(0, 1'b0, 1'b0); gap(P - 1);
    for (int i = 0; i < 4; i++) begin
      strobe(0, 1'b0, 1'b1); gap(P - 1);
    end
    check("rst_pre_dav", dav[0], 1'b1);
    reset = 1'b1;
    gap(1);
    check("rst_outputs", {d_8e1, vld[0], perr[0], ferr[0], ovr[0], dav[0], ips[0], div[0]}, 0);
    reset = 1'b0;
    gap(2);
    send_frame(0, 9'h081, 8, 1, 1'b0, 1, 1'b1, 1'b1, 0);
    check("81_data", d_8e1, 8'h81);
    check("81_valid", vld[0], 1'b1);
    check("81_perr", perr[0], 1'b0);
    check("81_ferr", ferr[0], 1'b0);
    gap(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
